// File: rtl/digdug_cus06_seq.sv
`default_nettype none
// ============================================================================
// Module   : digdug_cus06_seq
// Purpose  : Sequencer / NMI scheduler between the main CPU and the DigDug
//            custom chips. Holds the CPU control register, raises the
//            periodic transfer NMI and turns each CPU data or command access
//            into a one-cycle strobe on the shared chip bus. Read data is
//            prefetched into RDBUF so CPU reads never wait on a chip.
// Ports    : CL, RESET (async, active-high)
//            CS/WR/A/DI  - CPU access (A: 0 data, 1 control, 2 command)
//            DO          - CPU read data (combinational on A)
//            NMI, BUSY   - transfer request / strobe in progress
//            CHIP_CS/WR/AD/DO - registered chip strobe outputs
//            CHIP_DI     - packed chip read data, chip n at [8n+7:8n]
// Revision : 1.0  initial release
// ============================================================================
module digdug_cus06_seq #(
  parameter int TICK_DIV = 64
) (
  input  logic        CL,
  input  logic        RESET,
  input  logic        CS,
  input  logic        WR,
  input  logic [1:0]  A,
  input  logic [7:0]  DI,
  output logic [7:0]  DO,
  output logic        NMI,
  output logic        BUSY,
  output logic [3:0]  CHIP_CS,
  output logic        CHIP_WR,
  output logic [4:0]  CHIP_AD,
  output logic [7:0]  CHIP_DO,
  input  logic [31:0] CHIP_DI
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = TW + 3;   // holds up to 7*TICK_DIV-1

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WSTB = 2'd1;
  localparam logic [1:0] S_RSTB = 2'd2;

  logic [1:0]    r_state;
  logic [7:0]    r_ctrl;
  logic [3:0]    r_idx;
  logic [7:0]    r_rdbuf;
  logic          r_nmi;
  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_chip_cs;
  logic          r_chip_wr;
  logic [4:0]    r_chip_ad;
  logic [7:0]    r_chip_do;

  logic          w_acc;
  logic          w_ctrl_wr;
  logic          w_cmd_wr;
  logic          w_data_acc;
  logic          w_data_wr;
  logic          w_data_rd;
  logic          w_pref;
  logic [3:0]    w_mask;
  logic [3:0]    w_tgt;
  logic [CW-1:0] w_period;
  logic          w_expire;
  logic [7:0]    w_rd_slice;

  // Accesses arriving while a strobe is in flight are dropped entirely.
  assign w_acc      = CS & ~r_busy;
  assign w_ctrl_wr  = w_acc & WR & (A == 2'd1);
  assign w_cmd_wr   = w_acc & WR & (A == 2'd2);
  assign w_data_acc = w_acc & (A == 2'd0);
  // A data access against the programmed direction only acknowledges NMI.
  assign w_data_wr  = w_data_acc &  WR & ~r_ctrl[4];
  assign w_data_rd  = w_data_acc & ~WR &  r_ctrl[4];
  assign w_pref     = w_ctrl_wr & DI[4] & (DI[3:0] != 4'd0);

  // The control-write prefetch must target the mask being written.
  assign w_mask = w_ctrl_wr ? DI[3:0] : r_ctrl[3:0];
  assign w_tgt  = w_mask & (~w_mask + 4'd1);   // isolate lowest set bit

  // Period = R * TICK_DIV; TICK_DIV is a power of two so this is a shift.
  assign w_period = {r_ctrl[7:5], {TW{1'b0}}};
  assign w_expire = (r_ctrl[7:5] != 3'd0) && (r_cnt == w_period - CW'(1));

  // The strobed chip select (registered) picks the slice captured into RDBUF.
  always_comb begin
    w_rd_slice = 8'hFF;
    case (r_chip_cs)
      4'b0001: w_rd_slice = CHIP_DI[7:0];
      4'b0010: w_rd_slice = CHIP_DI[15:8];
      4'b0100: w_rd_slice = CHIP_DI[23:16];
      4'b1000: w_rd_slice = CHIP_DI[31:24];
      default: w_rd_slice = 8'hFF;
    endcase
  end

  always_ff @(posedge CL or posedge RESET) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_ctrl    <= 8'h00;
      r_idx     <= 4'd0;
      r_rdbuf   <= 8'hFF;
      r_nmi     <= 1'b0;
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_chip_cs <= 4'd0;
      r_chip_wr <= 1'b0;
      r_chip_ad <= 5'd0;
      r_chip_do <= 8'd0;
    end else begin
      // Strobes last exactly one cycle; every strobe state returns to IDLE.
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_chip_cs <= 4'd0;
      r_chip_wr <= 1'b0;
      r_chip_ad <= 5'd0;
      r_chip_do <= 8'd0;

      if (r_state == S_RSTB) begin
        r_rdbuf <= w_rd_slice;
      end

      if ((r_ctrl[7:5] == 3'd0) || w_expire) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end

      // Expiry beats an acknowledge; a control write (below) beats both.
      if (w_expire) begin
        r_nmi <= 1'b1;
      end else if (w_data_acc) begin
        r_nmi <= 1'b0;
      end

      if (w_ctrl_wr) begin
        r_ctrl <= DI;
        r_idx  <= 4'd0;
        r_cnt  <= '0;
        r_nmi  <= 1'b0;
        if (w_pref) begin
          r_state   <= S_RSTB;
          r_busy    <= 1'b1;
          r_chip_cs <= w_tgt;
          r_chip_ad <= 5'h00;
          r_idx     <= 4'd1;
        end
      end else if (w_cmd_wr) begin
        r_state   <= S_WSTB;
        r_busy    <= 1'b1;
        r_chip_cs <= w_tgt;
        r_chip_wr <= 1'b1;
        r_chip_ad <= 5'h10;
        r_chip_do <= DI;
        r_idx     <= 4'd0;
      end else if (w_data_wr) begin
        r_state   <= S_WSTB;
        r_busy    <= 1'b1;
        r_chip_cs <= w_tgt;
        r_chip_wr <= 1'b1;
        r_chip_ad <= {1'b0, r_idx};
        r_chip_do <= DI;
        r_idx     <= r_idx + 4'd1;
      end else if (w_data_rd) begin
        r_state   <= S_RSTB;
        r_busy    <= 1'b1;
        r_chip_cs <= w_tgt;
        r_chip_ad <= {1'b0, r_idx};
        r_idx     <= r_idx + 4'd1;
      end
    end
  end

  always_comb begin
    DO = 8'hFF;
    case (A)
      2'd0:    DO = r_rdbuf;
      2'd1:    DO = r_ctrl;
      default: DO = 8'hFF;
    endcase
  end

  assign NMI     = r_nmi;
  assign BUSY    = r_busy;
  assign CHIP_CS = r_chip_cs;
  assign CHIP_WR = r_chip_wr;
  assign CHIP_AD = r_chip_ad;
  assign CHIP_DO = r_chip_do;

endmodule
`default_nettype wire

// File: tb/tb_digdug_cus06_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_digdug_cus06_seq
// Purpose  : Self-checking bench for digdug_cus06_seq. A behavioural model of
//            the sequencer predicts every output each cycle; directed
//            sequences pin the model with literal expectations, then random
//            CPU traffic runs against it.
// Revision : 1.0  initial release
// ============================================================================
module tb_digdug_cus06_seq;

  localparam int TICK_DIV = 64;

  logic        CL = 1'b0;
  logic        RESET = 1'b0;
  logic        CS = 1'b0;
  logic        WR = 1'b0;
  logic [1:0]  A = 2'd0;
  logic [7:0]  DI = 8'd0;
  logic [7:0]  DO;
  logic        NMI;
  logic        BUSY;
  logic [3:0]  CHIP_CS;
  logic        CHIP_WR;
  logic [4:0]  CHIP_AD;
  logic [7:0]  CHIP_DO;
  logic [31:0] CHIP_DI;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  digdug_cus06_seq #(.TICK_DIV(TICK_DIV)) dut (
    .CL(CL), .RESET(RESET), .CS(CS), .WR(WR), .A(A), .DI(DI), .DO(DO),
    .NMI(NMI), .BUSY(BUSY), .CHIP_CS(CHIP_CS), .CHIP_WR(CHIP_WR),
    .CHIP_AD(CHIP_AD), .CHIP_DO(CHIP_DO), .CHIP_DI(CHIP_DI)
  );

  always #5 CL = ~CL;

  // Chip n returns {n, 00, sub-address}: chip 1 gives 8'h40 + idx.
  function automatic logic [7:0] chipval(input logic [1:0] n, input logic [4:0] ad);
    return {n, 2'b00, ad[3:0]};
  endfunction

  assign CHIP_DI = {chipval(2'd3, CHIP_AD), chipval(2'd2, CHIP_AD),
                    chipval(2'd1, CHIP_AD), chipval(2'd0, CHIP_AD)};

  function automatic int lowest(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_ctrl, m_rdbuf, m_cdo;
  logic [3:0] m_idx, m_ccs;
  logic [4:0] m_cad;
  logic       m_nmi, m_busy, m_cwr, m_rd;
  int         m_cnt;

  initial forever begin
    @(posedge CL or posedge RESET);
    if (RESET) begin
      m_ctrl = 8'h00; m_idx = 4'd0; m_rdbuf = 8'hFF; m_nmi = 1'b0; m_cnt = 0;
      m_busy = 1'b0; m_ccs = 4'd0; m_cwr = 1'b0; m_cad = 5'd0; m_cdo = 8'd0; m_rd = 1'b0;
    end else begin
      int period, l;
      bit acc, expire;
      logic [3:0] mask;
      // read data is whatever the strobed chip presents during the strobe
      if (m_rd) begin
        l = lowest(m_ccs);
        m_rdbuf = (l < 0) ? 8'hFF : chipval(2'(l), m_cad);
      end
      acc    = CS && !m_busy;
      period = int'(m_ctrl[7:5]) * TICK_DIV;
      expire = (period != 0) && (m_cnt == period - 1);
      m_cnt  = (period == 0 || expire) ? 0 : m_cnt + 1;
      if (expire) m_nmi = 1'b1;
      else if (acc && A == 2'd0) m_nmi = 1'b0;
      m_busy = 1'b0; m_ccs = 4'd0; m_cwr = 1'b0; m_cad = 5'd0; m_cdo = 8'd0; m_rd = 1'b0;
      mask = m_ctrl[3:0];
      l = lowest(mask);
      if (acc) begin
        if (A == 2'd1 && WR) begin
          m_ctrl = DI; m_idx = 4'd0; m_cnt = 0; m_nmi = 1'b0;
          if (DI[4] && DI[3:0] != 4'd0) begin
            l = lowest(DI[3:0]);
            m_busy = 1'b1; m_ccs = 4'(1 << l); m_cad = 5'h00; m_rd = 1'b1;
            m_idx = 4'd1;
          end
        end else if (A == 2'd2 && WR) begin
          m_busy = 1'b1; m_ccs = (l < 0) ? 4'd0 : 4'(1 << l);
          m_cwr = 1'b1; m_cad = 5'h10; m_cdo = DI; m_idx = 4'd0;
        end else if (A == 2'd0 && WR && !m_ctrl[4]) begin
          m_busy = 1'b1; m_ccs = (l < 0) ? 4'd0 : 4'(1 << l);
          m_cwr = 1'b1; m_cad = {1'b0, m_idx}; m_cdo = DI;
          m_idx = 4'((int'(m_idx) + 1) % 16);
        end else if (A == 2'd0 && !WR && m_ctrl[4]) begin
          m_busy = 1'b1; m_ccs = (l < 0) ? 4'd0 : 4'(1 << l);
          m_cad = {1'b0, m_idx}; m_rd = 1'b1;
          m_idx = 4'((int'(m_idx) + 1) % 16);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge CL);
    if (chk_en) begin
      logic [7:0] exp_do;
      exp_do = (A == 2'd1) ? m_ctrl : (A == 2'd0) ? m_rdbuf : 8'hFF;
      chk("DO", 32'(DO), 32'(exp_do));
      chk("NMI", 32'(NMI), 32'(m_nmi));
      chk("BUSY", 32'(BUSY), 32'(m_busy));
      chk("CHIP_CS", 32'(CHIP_CS), 32'(m_ccs));
      chk("CHIP_WR", 32'(CHIP_WR), 32'(m_cwr));
      chk("CHIP_AD", 32'(CHIP_AD), 32'(m_cad));
      chk("CHIP_DO", 32'(CHIP_DO), 32'(m_cdo));
    end
  end

  // ---------------- directed + random stimulus ----------------
  logic [3:0] s_cs, s_cs2;
  logic [4:0] s_ad;
  logic [7:0] s_do;
  logic       s_wr, s_busy;

  task automatic tick();
    @(posedge CL); #1;
  endtask

  // One CPU access, then record the strobe cycle and the cycle after.
  task automatic acc(input logic w, input logic [1:0] a, input logic [7:0] d);
    CS = 1'b1; WR = w; A = a; DI = d;
    tick();
    CS = 1'b0; WR = 1'b0; A = 2'd0;
    s_cs = CHIP_CS; s_wr = CHIP_WR; s_ad = CHIP_AD; s_do = CHIP_DO; s_busy = BUSY;
    tick();
    s_cs2 = CHIP_CS;
  endtask

  initial begin
    int k;
    #2 RESET = 1'b1;
    chk_en = 1'b1;
    tick();
    RESET = 1'b0;
    chk("reset_DO", 32'(DO), 32'hFF);
    chk("reset_NMI", 32'(NMI), 32'h0);
    chk("reset_CHIP_CS", 32'(CHIP_CS), 32'h0);

    // command then four data writes to chip 0
    acc(1'b1, 2'd1, 8'h01);
    acc(1'b1, 2'd2, 8'hC1);
    chk("cmd_cs", 32'(s_cs), 32'h1);
    chk("cmd_ad", 32'(s_ad), 32'h10);
    chk("cmd_do", 32'(s_do), 32'hC1);
    chk("cmd_wr", 32'(s_wr), 32'h1);
    chk("cmd_one_cycle", 32'(s_cs2), 32'h0);
    for (int i = 0; i < 4; i++) begin
      acc(1'b1, 2'd0, 8'(i + 2));
      chk("dwr_ad", 32'(s_ad), 32'(i));
      chk("dwr_do", 32'(s_do), 32'(i + 2));
      chk("dwr_cs", 32'(s_cs), 32'h1);
    end

    // read mode on chip 1 with prefetch; idx wraps after 16 reads
    acc(1'b1, 2'd1, 8'h32);
    chk("prefetch_cs", 32'(s_cs), 32'h2);
    chk("first_read", 32'(DO), 32'h40);
    for (int i = 0; i < 16; i++) begin
      acc(1'b0, 2'd0, 8'h00);
      chk("read_seq", 32'(DO), 32'(8'h40 + 8'((i + 1) % 16)));
    end

    // mask 1010 strobes only chip 1
    acc(1'b1, 2'd1, 8'h1A);
    chk("mask1010_pref", 32'(s_cs), 32'h2);
    acc(1'b0, 2'd0, 8'h00);
    chk("mask1010_cs", 32'(s_cs), 32'h2);
    chk("mask1010_do", 32'(DO), 32'h41);

    // mask 0 read returns FF, no chip select
    acc(1'b1, 2'd1, 8'h10);
    chk("mask0_nopref", 32'(s_busy), 32'h0);
    acc(1'b0, 2'd0, 8'h00);
    chk("mask0_cs", 32'(s_cs), 32'h0);
    chk("mask0_do", 32'(DO), 32'hFF);

    // timer: R=1 -> NMI 64 cycles after the control write
    CS = 1'b1; WR = 1'b1; A = 2'd1; DI = 8'h21;
    tick();
    CS = 1'b0; WR = 1'b0; A = 2'd0;
    k = 0;
    while (!NMI && k < 200) begin tick(); k++; end
    chk("nmi_first", 32'(k), 32'd64);
    CS = 1'b1; WR = 1'b1; A = 2'd0; DI = 8'h77;
    tick();
    CS = 1'b0; WR = 1'b0;
    chk("nmi_ack", 32'(NMI), 32'h0);
    k = 1;
    while (!NMI && k < 200) begin tick(); k++; end
    chk("nmi_period", 32'(k), 32'd64);
    repeat (63) tick();
    CS = 1'b1; WR = 1'b1; A = 2'd0; DI = 8'h88;
    tick();
    CS = 1'b0; WR = 1'b0;
    chk("nmi_set_wins", 32'(NMI), 32'h1);
    repeat (63) tick();
    CS = 1'b1; WR = 1'b1; A = 2'd1; DI = 8'h21;
    tick();
    CS = 1'b0; WR = 1'b0; A = 2'd0;
    chk("nmi_ctrl_wins", 32'(NMI), 32'h0);
    k = 0;
    while (!NMI && k < 200) begin tick(); k++; end
    chk("nmi_restart", 32'(k), 32'd64);

    // access during BUSY is ignored
    acc(1'b1, 2'd1, 8'h01);
    CS = 1'b1; WR = 1'b1; A = 2'd0; DI = 8'hAA;
    tick();
    A = 2'd2; DI = 8'h55;
    tick();
    CS = 1'b0; WR = 1'b0; A = 2'd0;
    chk("busy_ign_cs", 32'(CHIP_CS), 32'h0);
    acc(1'b1, 2'd0, 8'hBB);
    chk("busy_ign_idx", 32'(s_ad), 32'h01);

    // RESET in the middle of a write strobe
    CS = 1'b1; WR = 1'b1; A = 2'd0; DI = 8'hCC;
    tick();
    CS = 1'b0; WR = 1'b0;
    chk("wstb_busy", 32'(BUSY), 32'h1);
    RESET = 1'b1;
    #1;
    chk("rst_cs", 32'(CHIP_CS), 32'h0);
    chk("rst_wr", 32'(CHIP_WR), 32'h0);
    chk("rst_do", 32'(CHIP_DO), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    chk("rst_rdbuf", 32'(DO), 32'hFF);
    tick();
    RESET = 1'b0;
    tick();
    chk("rst_after_cs", 32'(CHIP_CS), 32'h0);

    // random traffic
    repeat (3000) begin
      CS = ($urandom_range(0, 2) == 0);
      WR = 1'($urandom_range(0, 1));
      A  = 2'($urandom_range(0, 3));
      DI = 8'($urandom);
      if (A == 2'd1 && WR && $urandom_range(0, 7) != 0) A = 2'd0;
      if (A == 2'd1 && $urandom_range(0, 1) == 0) DI[7:5] = 3'd1;
      if ($urandom_range(0, 599) == 0) RESET = 1'b1;
      tick();
      RESET = 1'b0;
    end
    CS = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
